// File: rtl/game_seq_pkg.sv
// Shared types and defaults for the game request sequencer.
// Watchdog is built only with GAME_SEQ_WATCHDOG_EN.
package game_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RUN,
    GAP,
    ERR
  } seq_state_t;

  localparam int unsigned DEF_INTERVAL_CYCLES = 1000;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 100000000;
  localparam int unsigned DEF_CNT_W           = 16;

  // Bits needed to hold n-1 (at least one bit).
  function automatic int unsigned cnt_bits(
    input int unsigned n
  );
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/game_req_sequencer_if.sv
// Request/busy handshake towards the game manager.
// master = sequencer side, slave = game manager side.
interface game_req_sequencer_if;
  logic gm_req;
  logic gm_busy;

  modport master (
    output gm_req,
    input  gm_busy
  );

  modport slave (
    input  gm_req,
    output gm_busy
  );
endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter; done is high while the count is zero.
// Used for the GAP delay and the watchdog.
module seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (enable && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/game_req_sequencer.sv
// Issues game requests (single or free-run) to a game manager.
// Optional watchdog/ERR state: define GAME_SEQ_WATCHDOG_EN.
module game_req_sequencer
  import game_seq_pkg::*;
#(
  parameter int unsigned INTERVAL_CYCLES = DEF_INTERVAL_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 run,
  input  logic                 single,
  input  logic                 err_clear,
  game_req_sequencer_if.master gm,
  output logic                 active,
  output logic [CNT_W-1:0]     game_count,
  output logic                 timeout_err
);

  // A zero interval still spends one cycle in GAP.
  localparam int unsigned GAP_N =
    (INTERVAL_CYCLES == 0) ? 1 : INTERVAL_CYCLES;
  localparam int unsigned GAP_W = cnt_bits(GAP_N);
  localparam logic [GAP_W-1:0] GAP_LOAD =
    GAP_W'(GAP_N - 1);

  seq_state_t       state_q, state_d;
  logic             gm_req_q, gm_req_d;
  logic             active_q, active_d;
  logic [CNT_W-1:0] game_count_q, game_count_d;

  logic gap_load, gap_en, gap_done;
  logic wd_done;

  seq_timer #(.W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .enable   (gap_en),
    .done     (gap_done)
  );

`ifdef GAME_SEQ_WATCHDOG_EN
  localparam int unsigned WD_N =
    (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
  localparam int unsigned WD_W = cnt_bits(WD_N);
  localparam logic [WD_W-1:0] WD_LOAD =
    WD_W'(WD_N - 1);

  logic wd_load, wd_en;
  logic timeout_err_q, timeout_err_d;

  assign wd_load = (state_d == REQ) && (state_q != REQ);
  assign wd_en   = (state_q == REQ) || (state_q == RUN);

  seq_timer #(.W(WD_W)) u_wd_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (wd_load),
    .load_val (WD_LOAD),
    .enable   (wd_en),
    .done     (wd_done)
  );

  assign timeout_err_d = (state_d == ERR);
  assign timeout_err   = timeout_err_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
  assign wd_done     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    game_count_d = game_count_q;
    unique case (state_q)
      IDLE: if (run || single) state_d = REQ;
      REQ: begin
        if (wd_done)         state_d = ERR;
        else if (gm.gm_busy) state_d = RUN;
      end
      RUN: begin
        if (wd_done) begin
          state_d = ERR;
        end else if (!gm.gm_busy) begin
          game_count_d = game_count_q + 1'b1;
          state_d      = run ? GAP : IDLE;
        end
      end
      GAP: if (gap_done) state_d = run ? REQ : IDLE;
      ERR: if (err_clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    gm_req_d = (state_d == REQ);
    active_d = (state_d == REQ) ||
               (state_d == RUN) ||
               (state_d == GAP);
  end

  assign gap_load = (state_q == RUN) && (state_d == GAP);
  assign gap_en   = (state_q == GAP);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      gm_req_q      <= 1'b0;
      active_q      <= 1'b0;
      game_count_q  <= '0;
`ifdef GAME_SEQ_WATCHDOG_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      gm_req_q      <= gm_req_d;
      active_q      <= active_d;
      game_count_q  <= game_count_d;
`ifdef GAME_SEQ_WATCHDOG_EN
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign gm.gm_req  = gm_req_q;
  assign active     = active_q;
  assign game_count = game_count_q;

endmodule

// File: tb/tb_game_req_sequencer.sv
// Directed bench: vector table plus multi-cycle corner sequences.
// INTERVAL_CYCLES=4, TIMEOUT_CYCLES=20, CNT_W=4.
module tb_game_req_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run = 1'b0;
  logic       single = 1'b0;
  logic       err_clear = 1'b0;
  logic       active;
  logic [3:0] game_count;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  game_req_sequencer_if gm ();

  game_req_sequencer #(
    .INTERVAL_CYCLES (4),
    .TIMEOUT_CYCLES  (20),
    .CNT_W           (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .run         (run),
    .single      (single),
    .err_clear   (err_clear),
    .gm          (gm),
    .active      (active),
    .game_count  (game_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_n;
    logic       run;
    logic       sgl;
    logic       busy;
    logic       clr;
    logic       req;
    logic       act;
    logic [3:0] cnt;
    logic       terr;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] want
  );
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, got, want);
    end
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    run         = 1'b0;
    single      = 1'b0;
    err_clear   = 1'b0;
    gm.gm_busy  = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    int stray;
    gm.gm_busy = 1'b0;

    //         rst run sgl bsy clr  req act cnt terr
    tbl[0]  = '{0, 0, 0, 0, 0,  0, 0, 4'd0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0,  0, 0, 4'd0, 0};
    tbl[2]  = '{1, 0, 1, 0, 0,  1, 1, 4'd0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0,  1, 1, 4'd0, 0};
    tbl[4]  = '{1, 0, 0, 1, 0,  0, 1, 4'd0, 0};
    tbl[5]  = '{1, 0, 0, 1, 0,  0, 1, 4'd0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0,  0, 0, 4'd1, 0};
    tbl[7]  = '{1, 0, 0, 0, 0,  0, 0, 4'd1, 0};
    tbl[8]  = '{1, 0, 0, 1, 0,  0, 0, 4'd1, 0};
    tbl[9]  = '{1, 0, 0, 0, 1,  0, 0, 4'd1, 0};
    tbl[10] = '{1, 1, 1, 0, 0,  1, 1, 4'd1, 0};
    tbl[11] = '{1, 1, 0, 1, 0,  0, 1, 4'd1, 0};
    tbl[12] = '{1, 0, 0, 1, 0,  0, 1, 4'd1, 0};
    tbl[13] = '{1, 0, 0, 0, 0,  0, 0, 4'd2, 0};
    tbl[14] = '{1, 0, 0, 1, 0,  0, 0, 4'd2, 0};
    tbl[15] = '{1, 0, 1, 1, 0,  1, 1, 4'd2, 0};
    tbl[16] = '{1, 0, 0, 1, 0,  0, 1, 4'd2, 0};
    tbl[17] = '{1, 0, 0, 0, 0,  0, 0, 4'd3, 0};
    tbl[18] = '{1, 1, 0, 0, 0,  1, 1, 4'd3, 0};
    tbl[19] = '{1, 1, 0, 1, 0,  0, 1, 4'd3, 0};
    tbl[20] = '{1, 1, 0, 0, 0,  0, 1, 4'd4, 0};
    tbl[21] = '{1, 1, 0, 1, 0,  0, 1, 4'd4, 0};
    tbl[22] = '{1, 1, 0, 1, 0,  0, 1, 4'd4, 0};
    tbl[23] = '{1, 1, 0, 1, 0,  0, 1, 4'd4, 0};
    tbl[24] = '{1, 1, 0, 0, 0,  1, 1, 4'd4, 0};
    tbl[25] = '{1, 0, 0, 1, 0,  0, 1, 4'd4, 0};
    tbl[26] = '{1, 0, 0, 0, 0,  0, 0, 4'd5, 0};

    step();
    for (int i = 0; i < NV; i++) begin
      reset_n    = tbl[i].rst_n;
      run        = tbl[i].run;
      single     = tbl[i].sgl;
      gm.gm_busy = tbl[i].busy;
      err_clear  = tbl[i].clr;
      step();
      chk($sformatf("v%0d_req", i),
          32'(gm.gm_req), 32'(tbl[i].req));
      chk($sformatf("v%0d_act", i),
          32'(active), 32'(tbl[i].act));
      chk($sformatf("v%0d_cnt", i),
          32'(game_count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_terr", i),
          32'(timeout_err), 32'(tbl[i].terr));
    end

    // Free-run: ack 2 cycles after gm_req, busy 5 cycles.
    do_reset();
    run = 1'b1;
    step();
    chk("fr_lat", 32'(gm.gm_req), 32'd1);
    for (int g = 0; g < 3; g++) begin
      gm.gm_busy = 1'b0;
      step();
      chk($sformatf("fr%0d_wait", g),
          32'(gm.gm_req), 32'd1);
      gm.gm_busy = 1'b1;
      step();
      chk($sformatf("fr%0d_ack", g),
          32'(gm.gm_req), 32'd0);
      repeat (4) step();
      gm.gm_busy = 1'b0;
      step();
      chk($sformatf("fr%0d_cnt", g),
          32'(game_count), 32'(g + 1));
      n = 0;
      while (!gm.gm_req && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("fr%0d_gap", g), 32'(n), 32'd4);
    end
    run = 1'b0;
    gm.gm_busy = 1'b1;
    step();
    gm.gm_busy = 1'b0;
    step();
    chk("fr_end_act", 32'(active), 32'd0);
    chk("fr_end_cnt", 32'(game_count), 32'd4);

    // Watchdog: busy never rises.
    do_reset();
    run = 1'b1;
    step();
    chk("to_req", 32'(gm.gm_req), 32'd1);
    repeat (19) step();
    chk("to_pre", 32'(gm.gm_req), 32'd1);
    step();
`ifdef GAME_SEQ_WATCHDOG_EN
    chk("to_req0", 32'(gm.gm_req), 32'd0);
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_act", 32'(active), 32'd0);
    repeat (3) step();
    chk("to_hold", 32'(timeout_err), 32'd1);
    run = 1'b0;
    single = 1'b1;
    step();
    single = 1'b0;
    chk("to_sgl", 32'(gm.gm_req), 32'd0);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("to_clr", 32'(timeout_err), 32'd0);
    chk("to_clr_act", 32'(active), 32'd0);
    step();
    chk("to_idle", 32'(gm.gm_req), 32'd0);
`else
    chk("to_nowd_req", 32'(gm.gm_req), 32'd1);
    chk("to_nowd_err", 32'(timeout_err), 32'd0);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    repeat (5) step();
    chk("to_nowd_hold", 32'(gm.gm_req), 32'd1);
    chk("to_nowd_err2", 32'(timeout_err), 32'd0);
    run = 1'b0;
    gm.gm_busy = 1'b1;
    step();
    gm.gm_busy = 1'b0;
    step();
    chk("to_nowd_done", 32'(active), 32'd0);
`endif

    // Counter wrap over 16 single games.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      single = 1'b1;
      step();
      single = 1'b0;
      gm.gm_busy = 1'b1;
      step();
      gm.gm_busy = 1'b0;
      step();
      chk($sformatf("wr%0d_cnt", i),
          32'(game_count), 32'((i + 1) % 16));
    end

    // Drop run mid-game: game completes, no new request.
    run = 1'b1;
    step();
    chk("ms_req", 32'(gm.gm_req), 32'd1);
    gm.gm_busy = 1'b1;
    step();
    run = 1'b0;
    step();
    chk("ms_run", 32'(active), 32'd1);
    gm.gm_busy = 1'b0;
    step();
    chk("ms_cnt", 32'(game_count), 32'd1);
    chk("ms_act", 32'(active), 32'd0);
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (gm.gm_req) stray++;
    end
    chk("ms_stray", 32'(stray), 32'd0);

    // Reset during RUN with busy high.
    run = 1'b1;
    step();
    gm.gm_busy = 1'b1;
    step();
    chk("rs_run", 32'(active), 32'd1);
    reset_n = 1'b0;
    step();
    chk("rs_req", 32'(gm.gm_req), 32'd0);
    chk("rs_act", 32'(active), 32'd0);
    chk("rs_cnt", 32'(game_count), 32'd0);
    chk("rs_terr", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;
    run = 1'b0;
    gm.gm_busy = 1'b0;
    step();
    chk("rs_after_cnt", 32'(game_count), 32'd0);
    chk("rs_after_act", 32'(active), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
